aes_encrypt_iterative: RTL and testbench

- Iterative AES-128 encryption core: the forward (cipher) counterpart of the existing inverse-round decrypt datapath.
- Computes one full round per clock, reusing the forward round primitives: SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Expands the key schedule on the fly, one round key per cycle.
- Sits between the block source and any downstream consumer, with valid/ready handshakes on both sides.
- Exports the final (round-10) key so a decrypt path can start its inverse schedule from it.

---
 rtl/aes_encrypt_iterative_if.sv | 34 +++
 rtl/aes_encrypt_iterative.sv | 180 ++++++++++++++++++
 tb/tb_aes_encrypt_iterative.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_iterative_if.sv
// ----------------------------------------------------------------------------
// aes_encrypt_iterative_if
// Block-level bus of the iterative AES-128 encryption core.
//   Input side : in_valid / in_ready handshake carrying plaintext and key.
//   Output side: out_valid / out_ready handshake carrying ciphertext and the
//                final round key (last_key), which a decrypt path can use to
//                start its inverse key schedule.
// All 128-bit fields are [0:127] with bits 0:7 holding FIPS-197 byte 0
// (column-major state order).
// Modports:
//   master - block source / consumer side (drives in_valid, plaintext, key,
//            out_ready)
//   slave  - the encryption core
// ----------------------------------------------------------------------------
interface aes_encrypt_iterative_if;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   plaintext;
    logic [0:127]   key;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   ciphertext;
    logic [0:127]   last_key;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, last_key
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, last_key
    );
endinterface

// File: rtl/aes_encrypt_iterative.sv
// ----------------------------------------------------------------------------
// aes_encrypt_iterative
// Iterative AES-128 encryption core: one full cipher round per clock with the
// key schedule expanded on the fly (one round key per cycle).
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset; discards any block in flight
//   bus  - aes_encrypt_iterative_if.slave:
//            in_valid/in_ready/plaintext/key      accept side
//            out_valid/out_ready/ciphertext/last_key  result side
// Timing: a block accepted at edge N raises out_valid after edge N+10. The
// result is held in DONE until out_ready; in_ready stays low until then.
// All outputs are registered.
// ----------------------------------------------------------------------------
module aes_encrypt_iterative (
    input logic                    clk,
    input logic                    rst,
    aes_encrypt_iterative_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Forward S-box, entry i at bits [8*i +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: row r of column c is taken from
    // column (c + r) mod 4 of the input state.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(r + 4*c)*8 +: 8] = sbox(s[(r + 4*((c + r) % 4))*8 +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[(4*c + 0)*8 +: 8];
            a1 = s[(4*c + 1)*8 +: 8];
            a2 = s[(4*c + 2)*8 +: 8];
            a3 = s[(4*c + 3)*8 +: 8];
            o[(4*c + 0)*8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[(4*c + 1)*8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[(4*c + 2)*8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[(4*c + 3)*8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // One AES-128 key-schedule step: RotWord/SubWord/Rcon on word 3, then
    // XOR-chained through words 0..3.
    function automatic logic [0:127] next_key(input logic [0:127] k,
                                              input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[0:31];
        w1 = k[32:63];
        w2 = k[64:95];
        w3 = k[96:127];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   fsm;
    logic [3:0]   rnd;
    logic [0:127] state_reg;
    logic [0:127] key_reg;

    logic [0:127] round_key;
    logic [0:127] shifted;
    logic [0:127] next_state;

    assign round_key  = next_key(key_reg, rcon(rnd));
    assign shifted    = sub_shift(state_reg);
    // The final round skips MixColumns.
    assign next_state = ((rnd == 4'd10) ? shifted : mix_columns(shifted)) ^ round_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm            <= IDLE;
            rnd            <= 4'd0;
            state_reg      <= '0;
            key_reg        <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.ciphertext <= '0;
            bus.last_key   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        state_reg    <= bus.plaintext ^ bus.key;
                        key_reg      <= bus.key;
                        rnd          <= 4'd1;
                        bus.in_ready <= 1'b0;
                        fsm          <= RUN;
                    end
                end
                RUN: begin
                    key_reg   <= round_key;
                    state_reg <= next_state;
                    if (rnd == 4'd10) begin
                        bus.ciphertext <= next_state;
                        bus.last_key   <= round_key;
                        bus.out_valid  <= 1'b1;
                        rnd            <= 4'd0;
                        fsm            <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    // in_ready rises only once the result has been taken, so
                    // a new block is never accepted in the handshake cycle.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        fsm           <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// ----------------------------------------------------------------------------
// tb_aes_encrypt_iterative
// Self-checking bench for aes_encrypt_iterative: FIPS-197 known answers,
// random vectors against a byte-level AES-128 reference model (S-box derived
// from GF(2^8) inversion plus the affine map), backpressure, input churn
// during a run and reset in the middle of a run.
// ----------------------------------------------------------------------------
module tb_aes_encrypt_iterative;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_encrypt_iterative_if bus ();

    aes_encrypt_iterative dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] sbox_ref [256];

    // Reference model arithmetic in GF(2^8).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box = affine(multiplicative inverse), inverse of 0 taken as 0.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic modelEncrypt(input logic [0:127] pt, input logic [0:127] k,
                                output logic [0:127] ct, output logic [0:127] lk);
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = k[(4*i + j)*8 +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp[0] = sbox_ref[w[i-1][1]] ^ rc;
                tmp[1] = sbox_ref[w[i-1][2]];
                tmp[2] = sbox_ref[w[i-1][3]];
                tmp[3] = sbox_ref[w[i-1][0]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[i*8 +: 8] ^ w[i/4][i%4];
        for (int round = 1; round <= 10; round++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = sbox_ref[s[r + 4*((c + r) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (round < 10) begin
                    s[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*round + c][r];
            end
        end
        for (int i = 0; i < 16; i++) begin
            ct[i*8 +: 8] = s[i];
            lk[i*8 +: 8] = w[40 + i/4][i%4];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one block for a single cycle; in_ready must already be high.
    task automatic applyStimulus(input logic [0:127] pt, input logic [0:127] k);
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
    endtask

    // Accepts a block, waits for completion (bounded), checks latency and
    // result, optionally churning the inputs during the run.
    task automatic runBlock(input string tag, input logic [0:127] pt,
                            input logic [0:127] k, input logic [0:127] exp_ct,
                            input logic [0:127] exp_lk, input bit churn,
                            input bit release_out);
        int cycles;
        applyStimulus(pt, k);
        checkOutput({tag, "_in_ready_busy"}, 128'(bus.in_ready), 128'd0);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            if (churn) begin
                bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
                bus.key       = {$urandom, $urandom, $urandom, $urandom};
                bus.in_valid  = 1'($urandom_range(0, 1));
            end
            step();
            cycles++;
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, "_latency"}, 128'(cycles), 128'd10);
        checkOutput({tag, "_ciphertext"}, bus.ciphertext, exp_ct);
        checkOutput({tag, "_last_key"}, bus.last_key, exp_lk);
        if (release_out) begin
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            checkOutput({tag, "_out_valid_drop"}, 128'(bus.out_valid), 128'd0);
            checkOutput({tag, "_in_ready_back"}, 128'(bus.in_ready), 128'd1);
            checkOutput({tag, "_ct_kept"}, bus.ciphertext, exp_ct);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [0:127] c1_key, c1_pt, c1_ct, c1_lk;
    logic [0:127] r_pt, r_key, m_ct, m_lk;

    initial begin
        c1_key = 128'h000102030405060708090a0b0c0d0e0f;
        c1_pt  = 128'h00112233445566778899aabbccddeeff;
        c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        c1_lk  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        buildSbox();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_in_ready", 128'(bus.in_ready), 128'd1);
        checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("rst_ciphertext", bus.ciphertext, 128'd0);
        checkOutput("rst_last_key", bus.last_key, 128'd0);

        $display("[TB] FIPS-197 C.1");
        runBlock("c1", c1_pt, c1_key, c1_ct, c1_lk, 1'b0, 1'b1);

        $display("[TB] FIPS-197 B");
        runBlock("b", 128'h3243f6a8885a308d313198a2e0370734,
                 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3925841d02dc09fbdc118597196a0b32,
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 1'b1);

        $display("[TB] all-zero vector");
        modelEncrypt('0, '0, m_ct, m_lk);
        runBlock("zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, m_lk, 1'b0, 1'b1);

        $display("[TB] backpressure");
        runBlock("bp", c1_pt, c1_key, c1_ct, c1_lk, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid  = 1'b1;
            bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
            step();
            checkOutput("bp_out_valid", 128'(bus.out_valid), 128'd1);
            checkOutput("bp_in_ready", 128'(bus.in_ready), 128'd0);
            checkOutput("bp_ciphertext", bus.ciphertext, c1_ct);
            checkOutput("bp_last_key", bus.last_key, c1_lk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checkOutput("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("bp_release_in_ready", 128'(bus.in_ready), 128'd1);

        $display("[TB] random vectors");
        for (int v = 0; v < 6; v++) begin
            r_pt  = {$urandom, $urandom, $urandom, $urandom};
            r_key = {$urandom, $urandom, $urandom, $urandom};
            modelEncrypt(r_pt, r_key, m_ct, m_lk);
            runBlock("rand", r_pt, r_key, m_ct, m_lk, 1'b0, 1'b1);
        end

        $display("[TB] input churn during run");
        r_pt  = {$urandom, $urandom, $urandom, $urandom};
        r_key = {$urandom, $urandom, $urandom, $urandom};
        modelEncrypt(r_pt, r_key, m_ct, m_lk);
        runBlock("churn", r_pt, r_key, m_ct, m_lk, 1'b1, 1'b1);

        $display("[TB] reset mid-run");
        applyStimulus({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        checkOutput("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("midrst_ciphertext", bus.ciphertext, 128'd0);
        checkOutput("midrst_last_key", bus.last_key, 128'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("midrst_no_output", 128'(bus.out_valid), 128'd0);
        end
        runBlock("after_rst_c1", c1_pt, c1_key, c1_ct, c1_lk, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
